// File: rtl/tb_sched_pkg.sv
// Shared definitions for the TB port-B scheduler.
//   - direction codes carried on TB_doutb_sel[1:0]
//   - target codes carried on TB_doutb_sel[2]
//   - FSM state encoding
//   - issue-slot record carried through the read-latency delay line
package tb_sched_pkg;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_POS  = 2'b01;
    localparam logic [1:0] DIR_NEG  = 2'b10;
    localparam logic [1:0] DIR_NEW  = 2'b11;

    localparam logic TB_B      = 1'b0;
    localparam logic TB_B_CONS = 1'b1;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;

    // One issue slot; an idle slot is all zeros so the mapper sees sel=000.
    typedef struct packed {
        logic       enb;
        logic       tgt;
        logic [1:0] dir;
        logic       last;
    } tb_slot_t;

endpackage

// File: rtl/tb_doutb_sched_if.sv
// Handshake and port-B bundle for tb_doutb_sched.
//   b_*/cons_*   : request operands in, ack/vld/done strobes out
//   TB_enb/addrb : TB port-B read enable and address
//   TB_doutb_sel : {target, dir} select for the port-B output mapper
// master = loaders / BRAM side, slave = scheduler.
interface tb_doutb_sched_if #(
    parameter int unsigned TB_AW = 10,
    parameter int unsigned LEN_W = 8
);
    logic             b_req;
    logic [TB_AW-1:0] b_base;
    logic [LEN_W-1:0] b_len;
    logic [1:0]       b_dir;
    logic             b_ack;
    logic             b_vld;
    logic             b_done;

    logic             cons_req;
    logic [TB_AW-1:0] cons_base;
    logic [LEN_W-1:0] cons_len;
    logic [1:0]       cons_dir;
    logic             cons_ack;
    logic             cons_vld;
    logic             cons_done;

    logic             TB_enb;
    logic [TB_AW-1:0] TB_addrb;
    logic [2:0]       TB_doutb_sel;

    modport master (
        output b_req, b_base, b_len, b_dir,
        output cons_req, cons_base, cons_len, cons_dir,
        input  b_ack, b_vld, b_done, cons_ack, cons_vld, cons_done,
        input  TB_enb, TB_addrb, TB_doutb_sel
    );

    modport slave (
        input  b_req, b_base, b_len, b_dir,
        input  cons_req, cons_base, cons_len, cons_dir,
        output b_ack, b_vld, b_done, cons_ack, cons_vld, cons_done,
        output TB_enb, TB_addrb, TB_doutb_sel
    );

endinterface

// File: rtl/tb_sched_dly.sv
// Register shift line with asynchronous active-low clear.
//   clk, rst_n : clock and async clear
//   din        : value entering stage 0
//   tap        : value delayed by TAP cycles
//   dout       : value delayed by DEPTH cycles
module tb_sched_dly #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAP   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tap,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tap  = stage_q[TAP-1];
    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/tb_doutb_sched.sv
// TB read port-B sequencer/arbiter for the B and B_CONS operand loaders.
//   clk, sys_rst_n : clock, async active-low reset
//   bus (slave)    : loader requests/acks/valid/done, TB port-B enable/address, mapper select
// Grants one burst at a time, issues one row per cycle, and delays {target, dir} by RD_LAT
// (mapper select) and valid/done by RD_LAT+1 (mapper registered outputs).
// Define TB_SCHED_RR_EN for round-robin arbitration; otherwise B has fixed priority.
module tb_doutb_sched
    import tb_sched_pkg::*;
#(
    parameter int unsigned TB_AW  = 10,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned RD_LAT = 1
) (
    input logic             clk,
    input logic             sys_rst_n,
    tb_doutb_sched_if.slave bus
);

    logic             state_q, state_d;
    logic [TB_AW-1:0] addr_q, addr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             tgt_q, tgt_d;
    logic [1:0]       dir_q, dir_d;
    logic             b_ack_q, b_ack_d, cons_ack_q, cons_ack_d;
    logic             zdone_b_q, zdone_b_d, zdone_cons_q, zdone_cons_d;
    tb_slot_t         issue_q, issue_d;
    logic [TB_AW-1:0] addrb_q, addrb_d;
    tb_slot_t         sel_slot, out_slot;
    logic             grant, pick_cons;
    logic [LEN_W-1:0] win_len;
    logic             b_vld, cons_vld;
    logic             unused_slot_bits;

`ifdef TB_SCHED_RR_EN
    logic last_q;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            last_q <= TB_B_CONS;
        end else if (grant) begin
            last_q <= pick_cons;
        end
    end

    assign pick_cons = bus.cons_req & (~bus.b_req | (last_q == TB_B));
`else
    assign pick_cons = bus.cons_req & ~bus.b_req;
`endif

    // A zero-length grant leaves the FSM in IDLE while the loader still holds req during the
    // ack cycle, so no new grant is allowed while an ack is in flight.
    assign grant   = (state_q == ST_IDLE) & ~b_ack_q & ~cons_ack_q & (bus.b_req | bus.cons_req);
    assign win_len = pick_cons ? bus.cons_len : bus.b_len;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        tgt_d      = tgt_q;
        dir_d      = dir_q;
        b_ack_d    = 1'b0;
        cons_ack_d = 1'b0;
        issue_d    = '0;
        addrb_d    = '0;
        // Still IDLE during the ack cycle means the grant was zero-length.
        zdone_b_d    = b_ack_q & (state_q == ST_IDLE);
        zdone_cons_d = cons_ack_q & (state_q == ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    tgt_d      = pick_cons;
                    addr_d     = pick_cons ? bus.cons_base : bus.b_base;
                    dir_d      = pick_cons ? bus.cons_dir : bus.b_dir;
                    rem_d      = win_len;
                    b_ack_d    = ~pick_cons;
                    cons_ack_d = pick_cons;
                    state_d    = (win_len != '0) ? ST_BURST : ST_IDLE;
                end
            end
            ST_BURST: begin
                issue_d.enb  = 1'b1;
                issue_d.tgt  = tgt_q;
                issue_d.dir  = dir_q;
                issue_d.last = (rem_q == LEN_W'(1));
                addrb_d      = addr_q;
                addr_d       = addr_q + TB_AW'(1);
                rem_d        = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            tgt_q        <= TB_B;
            dir_q        <= DIR_IDLE;
            b_ack_q      <= 1'b0;
            cons_ack_q   <= 1'b0;
            zdone_b_q    <= 1'b0;
            zdone_cons_q <= 1'b0;
            issue_q      <= '0;
            addrb_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            tgt_q        <= tgt_d;
            dir_q        <= dir_d;
            b_ack_q      <= b_ack_d;
            cons_ack_q   <= cons_ack_d;
            zdone_b_q    <= zdone_b_d;
            zdone_cons_q <= zdone_cons_d;
            issue_q      <= issue_d;
            addrb_q      <= addrb_d;
        end
    end

    tb_sched_dly #(
        .WIDTH ($bits(tb_slot_t)),
        .DEPTH (RD_LAT + 1),
        .TAP   (RD_LAT)
    ) u_dly (
        .clk   (clk),
        .rst_n (sys_rst_n),
        .din   (issue_q),
        .tap   (sel_slot),
        .dout  (out_slot)
    );

    assign b_vld    = out_slot.enb & (out_slot.tgt == TB_B);
    assign cons_vld = out_slot.enb & (out_slot.tgt == TB_B_CONS);

    assign bus.b_ack        = b_ack_q;
    assign bus.cons_ack     = cons_ack_q;
    assign bus.b_vld        = b_vld;
    assign bus.cons_vld     = cons_vld;
    assign bus.b_done       = (b_vld & out_slot.last) | zdone_b_q;
    assign bus.cons_done    = (cons_vld & out_slot.last) | zdone_cons_q;
    assign bus.TB_enb       = issue_q.enb;
    assign bus.TB_addrb     = addrb_q;
    assign bus.TB_doutb_sel = sel_slot.enb ? {sel_slot.tgt, sel_slot.dir} : 3'b000;

    assign unused_slot_bits = ^{sel_slot.last, out_slot.dir};

endmodule

// File: tb/tb_tb_doutb_sched.sv
// Scoreboard bench for tb_doutb_sched (RD_LAT=1). Each observed ack pushes the burst's
// expected addresses, selects and valid/done flags, stamped with the cycle they are due.
module tb_tb_doutb_sched;
    import tb_sched_pkg::*;

    localparam int unsigned TB_AW  = 10;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned RD_LAT = 1;

    logic clk = 1'b0;
    logic sys_rst_n = 1'b0;

    always #5 clk = ~clk;

    tb_doutb_sched_if #(.TB_AW(TB_AW), .LEN_W(LEN_W)) bus ();

    tb_doutb_sched #(
        .TB_AW  (TB_AW),
        .LEN_W  (LEN_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    ev_t addr_q[$];
    ev_t sel_q[$];
    ev_t flg_q[$];
    bit  exp_tgt_q[$];

    int cyc = 0;
    int ack_cnt = 0;
    int exp_ack_cyc = -1;
    int n_vec = 0;
    int n_err = 0;
    int op_base[2];
    int op_len[2];
    int op_dir[2];

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Flags are {b_vld, cons_vld, b_done, cons_done}.
    function automatic void push_burst(input int tgt, input int t);
        int len = op_len[tgt];
        int sel = (tgt * 4) + op_dir[tgt];
        if (len == 0) begin
            flg_q.push_back('{t + 1, (tgt != 0) ? 1 : 2});
        end
        for (int k = 0; k < len; k++) begin
            int fl;
            addr_q.push_back('{t + 1 + k, (op_base[tgt] + k) % 1024});
            if (sel != 0) sel_q.push_back('{t + 1 + k + int'(RD_LAT), sel});
            if (tgt != 0) fl = 4 + ((k == len - 1) ? 1 : 0);
            else          fl = 8 + ((k == len - 1) ? 2 : 0);
            flg_q.push_back('{t + 2 + k + int'(RD_LAT), fl});
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t ev;
        int  e;
        int  obs;
        int  tgt;
        if (bus.b_ack || bus.cons_ack) begin
            tgt = bus.cons_ack ? 1 : 0;
            if (exp_tgt_q.size() > 0) check_val("ack_target", tgt, int'(exp_tgt_q.pop_front()));
            else check_val("spurious_ack", int'(bus.b_ack | bus.cons_ack), 0);
            if (exp_ack_cyc >= 0) check_val("ack_cycle", cyc, exp_ack_cyc);
            push_burst(tgt, cyc);
            exp_ack_cyc = (op_len[tgt] == 0) ? cyc + 2 : cyc + op_len[tgt] + 1;
            ack_cnt++;
        end

        if (addr_q.size() > 0 && addr_q[0].cyc == cyc) begin
            ev = addr_q.pop_front();
            check_val("enb", int'(bus.TB_enb), 1);
            check_val("addrb", int'(bus.TB_addrb), ev.val);
        end else if (bus.TB_enb) begin
            check_val("spurious_enb", int'(bus.TB_enb), 0);
        end

        e = 0;
        if (sel_q.size() > 0 && sel_q[0].cyc == cyc) begin
            ev = sel_q.pop_front();
            e = ev.val;
        end
        if (e != 0 || bus.TB_doutb_sel != 3'b000) check_val("sel", int'(bus.TB_doutb_sel), e);

        e = 0;
        if (flg_q.size() > 0 && flg_q[0].cyc == cyc) begin
            ev = flg_q.pop_front();
            e = ev.val;
        end
        obs = int'({bus.b_vld, bus.cons_vld, bus.b_done, bus.cons_done});
        if (e != 0 || obs != 0) check_val("vld_done", obs, e);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_op(input int tgt, input int base, input int len, input int dir);
        op_base[tgt] = base;
        op_len[tgt]  = len;
        op_dir[tgt]  = dir;
        if (tgt == 0) begin
            bus.b_base = TB_AW'(base);
            bus.b_len  = LEN_W'(len);
            bus.b_dir  = 2'(dir);
            bus.b_req  = 1'b1;
        end else begin
            bus.cons_base = TB_AW'(base);
            bus.cons_len  = LEN_W'(len);
            bus.cons_dir  = 2'(dir);
            bus.cons_req  = 1'b1;
        end
    endtask

    task automatic wait_acks(input int n, input int budget);
        int i = 0;
        while (ack_cnt < n && i < budget) begin
            step(1);
            i++;
        end
        if (ack_cnt < n) check_val("ack_timeout", ack_cnt, n);
    endtask

    task automatic wait_drain(input int budget);
        int i = 0;
        while ((addr_q.size() + sel_q.size() + flg_q.size()) > 0 && i < budget) begin
            step(1);
            i++;
        end
        if ((addr_q.size() + sel_q.size() + flg_q.size()) > 0)
            check_val("drain_timeout", addr_q.size() + sel_q.size() + flg_q.size(), 0);
    endtask

    task automatic single(input int tgt, input int base, input int len, input int dir);
        int target = ack_cnt + 1;
        set_op(tgt, base, len, dir);
        exp_tgt_q.push_back(tgt[0]);
        exp_ack_cyc = cyc + 1;
        wait_acks(target, 10);
        if (tgt == 0) bus.b_req = 1'b0;
        else bus.cons_req = 1'b0;
        wait_drain(len + 20);
        step(2);
    endtask

    task automatic check_outputs_zero(input string phase);
        check_val({phase, "_b_ack"}, int'(bus.b_ack), 0);
        check_val({phase, "_cons_ack"}, int'(bus.cons_ack), 0);
        check_val({phase, "_b_vld"}, int'(bus.b_vld), 0);
        check_val({phase, "_cons_vld"}, int'(bus.cons_vld), 0);
        check_val({phase, "_b_done"}, int'(bus.b_done), 0);
        check_val({phase, "_cons_done"}, int'(bus.cons_done), 0);
        check_val({phase, "_enb"}, int'(bus.TB_enb), 0);
        check_val({phase, "_addrb"}, int'(bus.TB_addrb), 0);
        check_val({phase, "_sel"}, int'(bus.TB_doutb_sel), 0);
    endtask

    initial begin
        int target;
        bus.b_req     = 1'b0;
        bus.b_base    = '0;
        bus.b_len     = '0;
        bus.b_dir     = 2'b00;
        bus.cons_req  = 1'b0;
        bus.cons_base = '0;
        bus.cons_len  = '0;
        bus.cons_dir  = 2'b00;

        step(2);
        check_outputs_zero("reset");
        sys_rst_n = 1'b1;
        step(2);

        single(0, 'h010, 4, 1);       // B POS burst
        single(1, 'h020, 2, 2);       // CONS NEG burst

        // Both requesters held high across three grants.
        target = ack_cnt + 3;
        set_op(0, 'h040, 2, 1);
        set_op(1, 'h080, 2, 2);
`ifdef TB_SCHED_RR_EN
        exp_tgt_q.push_back(1'b0);
        exp_tgt_q.push_back(1'b1);
        exp_tgt_q.push_back(1'b0);
`else
        exp_tgt_q.push_back(1'b0);
        exp_tgt_q.push_back(1'b0);
        exp_tgt_q.push_back(1'b0);
`endif
        exp_ack_cyc = cyc + 1;
        wait_acks(target, 40);
        bus.b_req    = 1'b0;
        bus.cons_req = 1'b0;
        wait_drain(30);
        step(2);

        single(0, 'h030, 0, 1);       // zero length: done only, no read
        single(0, 'h3FE, 4, 3);       // address wrap, NEW
        single(1, 'h050, 3, 0);       // CONS IDLE dir still reads
        single(0, 'h060, 2, 0);       // B IDLE dir: vld with sel 000

        // Reset during row 2 of a B burst.
        target = ack_cnt + 1;
        set_op(0, 'h100, 6, 1);
        exp_tgt_q.push_back(1'b0);
        exp_ack_cyc = cyc + 1;
        wait_acks(target, 10);
        bus.b_req = 1'b0;
        step(3);
        sys_rst_n = 1'b0;
        addr_q.delete();
        sel_q.delete();
        flg_q.delete();
        exp_ack_cyc = -1;
        #1;
        check_outputs_zero("midrst");
        step(3);
        sys_rst_n = 1'b1;
        step(2);
        single(1, 'h200, 2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
        $fatal(1);
    end

endmodule
